// File: rtl/rename_pkg.sv
// Shared types and sizing helpers for the rename/dispatch scheduler.
package rename_pkg;

    // Scheduler state: IDLE takes a fresh decode group, SPLIT drains a held remainder.
    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } sched_state_e;

    // Stores allowed into the Store Buffer in one dispatch cycle unless overridden.
    localparam int DEFAULT_MAX_ST_PER_CYCLE = 1;

    // Counter width able to hold 0..ROB_DEPTH.
    function automatic int rob_cnt_w(input int rob_depth);
        return $clog2(rob_depth + 1);
    endfunction

    // Counter width able to hold 0..SB_DEPTH.
    function automatic int sb_cnt_w(input int sb_depth);
        return $clog2(sb_depth + 1);
    endfunction

endpackage

// File: rtl/rename_dispatch_sched_prefix_sel.sv
// Combinational in-order prefix selector: takes pending slots in order until the
// first one that does not fit the ROB space or the store budget.
module dispatch_prefix_sel
    import rename_pkg::*;
#(
    parameter int W         = 4,
    parameter int ROB_CNT_W = 7
) (
    input  logic [W-1:0]         pending_i,
    input  logic [W-1:0]         is_store_i,
    input  logic [ROB_CNT_W-1:0] rob_free_i,
    input  logic [31:0]          st_budget_i,
    output logic [W-1:0]         mask_o
);

    logic [31:0] rob_free_ext;
    logic [31:0] acc_cnt;
    logic [31:0] st_cnt;
    logic        stop;

    assign rob_free_ext = 32'(rob_free_i);

    // Walk slots in program order; the first valid slot that fails ends the prefix.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        mask_o  = '0;
        acc_cnt = '0;
        st_cnt  = '0;
        stop    = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (pending_i[i] && !stop) begin
                if ((acc_cnt + 32'd1) <= rob_free_ext &&
                    (!is_store_i[i] || (st_cnt + 32'd1) <= st_budget_i)) begin
                    mask_o[i] = 1'b1;
                    acc_cnt   = acc_cnt + 32'd1;
                    if (is_store_i[i]) begin
                        st_cnt = st_cnt + 32'd1;
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rename_dispatch_sched.sv
// Dispatch scheduler between the decode output register and rename. Sends the
// largest in-order prefix that fits ROB/SB/store limits and splits groups that
// cannot go in one cycle, acknowledging the group only once fully dispatched.
module rename_dispatch_sched
    import rename_pkg::*;
#(
    parameter int  DISPATCH_WIDTH   = 4,
    parameter int  ROB_DEPTH        = 64,
    parameter int  SB_DEPTH         = 16,
    parameter int  MAX_ST_PER_CYCLE = DEFAULT_MAX_ST_PER_CYCLE,
    localparam int ROB_CNT_W        = rob_cnt_w(ROB_DEPTH),
    localparam int SB_CNT_W         = sb_cnt_w(SB_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      grp_valid_i,
    input  logic [DISPATCH_WIDTH-1:0] grp_slot_valid_i,
    input  logic [DISPATCH_WIDTH-1:0] grp_is_store_i,
    output logic                      grp_ready_o,
    input  logic [ROB_CNT_W-1:0]      rob_free_cnt_i,
    input  logic [SB_CNT_W-1:0]       sb_free_cnt_i,
    input  logic                      ds_ready_i,
    output logic [DISPATCH_WIDTH-1:0] disp_mask_o,
    output logic [DISPATCH_WIDTH-1:0] sb_alloc_req_o,
    output logic                      disp_fire_o,
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               split_cnt_o
);

    sched_state_e              state_q, state_d;
    logic [DISPATCH_WIDTH-1:0] rem_q, rem_d;
    logic [31:0]               stall_cnt_q, stall_cnt_d;
    logic [31:0]               split_cnt_q, split_cnt_d;

    logic [DISPATCH_WIDTH-1:0] pending;
    logic [DISPATCH_WIDTH-1:0] sel_mask;
    logic [DISPATCH_WIDTH-1:0] disp_mask;
    logic [DISPATCH_WIDTH-1:0] left;
    logic [31:0]               sb_free_ext;
    logic [31:0]               st_budget;
    logic                      disp_fire;
    logic                      done;

    // Slots still owed for the current group: fresh group in IDLE, remainder in SPLIT.
    always_comb begin
        pending = '0;
        if (grp_valid_i) begin
            pending = (state_q == IDLE) ? grp_slot_valid_i : rem_q;
        end
    end

    assign sb_free_ext = 32'(sb_free_cnt_i);
    assign st_budget   = (sb_free_ext < 32'(MAX_ST_PER_CYCLE)) ? sb_free_ext
                                                               : 32'(MAX_ST_PER_CYCLE);

    dispatch_prefix_sel #(
        .W         (DISPATCH_WIDTH),
        .ROB_CNT_W (ROB_CNT_W)
    ) u_prefix_sel (
        .pending_i   (pending),
        .is_store_i  (grp_is_store_i),
        .rob_free_i  (rob_free_cnt_i),
        .st_budget_i (st_budget),
        .mask_o      (sel_mask)
    );

    // Nothing leaves while reset, flush or downstream back-pressure is active.
    always_comb begin
        disp_mask = '0;
        if (!rst_i && !flush_i && ds_ready_i) begin
            disp_mask = sel_mask;
        end
    end

    assign disp_fire = |disp_mask;
    assign left      = pending & ~disp_mask;
    assign done      = (left == '0);

    // Next state, remainder and counter updates for the split/stall bookkeeping.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stall_cnt_d = stall_cnt_q;
        split_cnt_d = split_cnt_q;
        if (flush_i) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!done && disp_fire) begin
                        rem_d       = left;
                        state_d     = SPLIT;
                        split_cnt_d = split_cnt_q + 32'd1;
                    end else if (!disp_fire && pending != '0) begin
                        stall_cnt_d = stall_cnt_q + 32'd1;
                    end
                end
                SPLIT: begin
                    if (done) begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end else if (disp_fire) begin
                        rem_d = left;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            stall_cnt_q <= '0;
            split_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            split_cnt_q <= split_cnt_d;
        end
    end

    assign disp_mask_o    = disp_mask;
    assign sb_alloc_req_o = disp_mask & grp_is_store_i;
    assign disp_fire_o    = disp_fire;
    assign grp_ready_o    = grp_valid_i & done & ~flush_i & ~rst_i;
    assign stall_cnt_o    = stall_cnt_q;
    assign split_cnt_o    = split_cnt_q;

    // Upstream must keep the group presented while a remainder is outstanding.
    a_group_held_in_split: assert property (
        @(posedge clk_i) disable iff (rst_i || flush_i)
        (state_q == SPLIT) |-> grp_valid_i
    );

endmodule

// File: tb/tb_rename_dispatch_sched.sv
// Self-checking bench for rename_dispatch_sched: directed scenarios plus a
// randomized run, all compared against a behavioural model of the scheduler.
module tb_rename_dispatch_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        grp_valid_i;
    logic [3:0]  grp_slot_valid_i;
    logic [3:0]  grp_is_store_i;
    logic        grp_ready_o;
    logic [6:0]  rob_free_cnt_i;
    logic [4:0]  sb_free_cnt_i;
    logic        ds_ready_i;
    logic [3:0]  disp_mask_o;
    logic [3:0]  sb_alloc_req_o;
    logic        disp_fire_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] split_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Model state: whether a group is partly sent, which slots remain, counters.
    bit          m_split;
    logic [3:0]  m_rem;
    logic [31:0] m_stall;
    logic [31:0] m_splits;
    bit          need_hold;

    // Model outputs for the current cycle.
    logic [3:0]  e_mask;
    logic [3:0]  e_alloc;
    logic        e_fire;
    logic        e_ready;
    logic [3:0]  e_pend;

    always #5 clk_i = ~clk_i;

    rename_dispatch_sched dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .grp_valid_i      (grp_valid_i),
        .grp_slot_valid_i (grp_slot_valid_i),
        .grp_is_store_i   (grp_is_store_i),
        .grp_ready_o      (grp_ready_o),
        .rob_free_cnt_i   (rob_free_cnt_i),
        .sb_free_cnt_i    (sb_free_cnt_i),
        .ds_ready_i       (ds_ready_i),
        .disp_mask_o      (disp_mask_o),
        .sb_alloc_req_o   (sb_alloc_req_o),
        .disp_fire_o      (disp_fire_o),
        .stall_cnt_o      (stall_cnt_o),
        .split_cnt_o      (split_cnt_o)
    );

    // Take slots in program order while ROB space and the store budget allow.
    function automatic logic [3:0] ref_select(input logic [3:0] pend, input logic [3:0] st,
                                              input int rob, input int sb);
        logic [3:0] m = '0;
        int taken  = 0;
        int stores = 0;
        int budget = (sb < 1) ? sb : 1;
        for (int i = 0; i < 4; i++) begin
            if (pend[i]) begin
                if (taken + 1 > rob) break;
                if (st[i] && stores + 1 > budget) break;
                m[i] = 1'b1;
                taken++;
                if (st[i]) stores++;
            end
        end
        return m;
    endfunction

    task automatic eval_model();
        e_pend  = grp_valid_i ? (m_split ? m_rem : grp_slot_valid_i) : 4'b0000;
        e_mask  = (rst_i || flush_i || !ds_ready_i) ? 4'b0000
                : ref_select(e_pend, grp_is_store_i, int'(rob_free_cnt_i), int'(sb_free_cnt_i));
        e_alloc = e_mask & grp_is_store_i;
        e_fire  = (e_mask != 4'b0000);
        e_ready = grp_valid_i && ((e_pend & ~e_mask) == 4'b0000) && !flush_i && !rst_i;
    endtask

    // Advance the model over the coming clock edge, then step past that edge.
    task automatic tick();
        logic [3:0] left;
        eval_model();
        left      = e_pend & ~e_mask;
        need_hold = grp_valid_i && !e_ready && !flush_i && !rst_i;
        if (rst_i) begin
            m_split = 0; m_rem = '0; m_stall = '0; m_splits = '0;
        end else if (flush_i) begin
            m_split = 0; m_rem = '0;
        end else if (left == 4'b0000) begin
            m_split = 0; m_rem = '0;
        end else if (e_mask != 4'b0000) begin
            if (!m_split) m_splits = m_splits + 1;
            m_split = 1; m_rem = left;
        end else begin
            m_stall = m_stall + 1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [3:0] slots, input logic [3:0] st,
                          input int rob, input int sb, input logic rdy);
        grp_valid_i      = v;
        grp_slot_valid_i = slots;
        grp_is_store_i   = st;
        rob_free_cnt_i   = 7'(rob);
        sb_free_cnt_i    = 5'(sb);
        ds_ready_i       = rdy;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0;
        set_in(1'b1, 4'b1111, 4'b0000, 8, 16, 1'b1);
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b0000) begin failures++; $display("FAIL rst_mask got=%b exp=0000", disp_mask_o); end
        checks++; if (grp_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", grp_ready_o); end
        checks++; if (disp_fire_o !== 1'b0 || sb_alloc_req_o !== 4'b0000) begin failures++; $display("FAIL rst_fire got=%b/%b exp=0/0000", disp_fire_o, sb_alloc_req_o); end
        tick();
        tick();
        rst_i = 1'b0;
        set_in(1'b0, 4'b0000, 4'b0000, 8, 16, 1'b1);
        @(negedge clk_i);
        checks++; if (stall_cnt_o !== 32'd0 || split_cnt_o !== 32'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", stall_cnt_o, split_cnt_o); end
        tick();
    endtask

    task automatic test_full_group();
        set_in(1'b1, 4'b1111, 4'b0000, 8, 16, 1'b1);
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b1111) begin failures++; $display("FAIL full_mask got=%b exp=1111", disp_mask_o); end
        checks++; if (grp_ready_o !== 1'b1) begin failures++; $display("FAIL full_ready got=%b exp=1", grp_ready_o); end
        tick();
        set_in(1'b0, 4'b0000, 4'b0000, 8, 16, 1'b1);
        @(negedge clk_i);
        checks++; if (split_cnt_o !== 32'd0) begin failures++; $display("FAIL full_split got=%0d exp=0", split_cnt_o); end
        tick();
    endtask

    task automatic test_store_split();
        set_in(1'b1, 4'b1111, 4'b0110, 8, 16, 1'b1);
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b0011) begin failures++; $display("FAIL st_c0_mask got=%b exp=0011", disp_mask_o); end
        checks++; if (sb_alloc_req_o !== 4'b0010) begin failures++; $display("FAIL st_c0_alloc got=%b exp=0010", sb_alloc_req_o); end
        checks++; if (grp_ready_o !== 1'b0) begin failures++; $display("FAIL st_c0_ready got=%b exp=0", grp_ready_o); end
        tick();
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b1100) begin failures++; $display("FAIL st_c1_mask got=%b exp=1100", disp_mask_o); end
        checks++; if (grp_ready_o !== 1'b1) begin failures++; $display("FAIL st_c1_ready got=%b exp=1", grp_ready_o); end
        checks++; if (split_cnt_o !== 32'd1) begin failures++; $display("FAIL st_c1_split got=%0d exp=1", split_cnt_o); end
        tick();
    endtask

    task automatic test_rob_limit();
        logic [31:0] stall0;
        stall0 = m_stall;
        set_in(1'b1, 4'b1111, 4'b0000, 2, 16, 1'b1);
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b0011) begin failures++; $display("FAIL rob_c0_mask got=%b exp=0011", disp_mask_o); end
        tick();
        rob_free_cnt_i = 7'd0;
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b0000 || grp_ready_o !== 1'b0) begin failures++; $display("FAIL rob_c1 got=%b/%b exp=0000/0", disp_mask_o, grp_ready_o); end
        tick();
        rob_free_cnt_i = 7'd8;
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b1100 || grp_ready_o !== 1'b1) begin failures++; $display("FAIL rob_c2 got=%b/%b exp=1100/1", disp_mask_o, grp_ready_o); end
        checks++; if (stall_cnt_o !== stall0 + 32'd1) begin failures++; $display("FAIL rob_stall got=%0d exp=%0d", stall_cnt_o, stall0 + 32'd1); end
        tick();
    endtask

    task automatic test_sb_stop();
        set_in(1'b1, 4'b1010, 4'b0010, 8, 0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++; if (disp_mask_o !== 4'b0000) begin failures++; $display("FAIL sb_stall%0d_mask got=%b exp=0000", c, disp_mask_o); end
            checks++; if (stall_cnt_o !== m_stall) begin failures++; $display("FAIL sb_stall%0d_cnt got=%0d exp=%0d", c, stall_cnt_o, m_stall); end
            tick();
        end
        sb_free_cnt_i = 5'd1;
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b1010 || grp_ready_o !== 1'b1) begin failures++; $display("FAIL sb_go got=%b/%b exp=1010/1", disp_mask_o, grp_ready_o); end
        checks++; if (stall_cnt_o !== m_stall) begin failures++; $display("FAIL sb_go_cnt got=%0d exp=%0d", stall_cnt_o, m_stall); end
        tick();
    endtask

    task automatic test_flush();
        set_in(1'b1, 4'b1111, 4'b0110, 8, 16, 1'b1);
        tick();
        flush_i = 1'b1;
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b0000 || grp_ready_o !== 1'b0 || disp_fire_o !== 1'b0) begin failures++; $display("FAIL flush_out got=%b/%b/%b exp=0000/0/0", disp_mask_o, grp_ready_o, disp_fire_o); end
        tick();
        flush_i = 1'b0;
        set_in(1'b1, 4'b0001, 4'b0000, 8, 16, 1'b1);
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b0001 || grp_ready_o !== 1'b1) begin failures++; $display("FAIL flush_next got=%b/%b exp=0001/1", disp_mask_o, grp_ready_o); end
        checks++; if (split_cnt_o !== m_splits || stall_cnt_o !== m_stall) begin failures++; $display("FAIL flush_counters got=%0d/%0d exp=%0d/%0d", split_cnt_o, stall_cnt_o, m_splits, m_stall); end
        tick();
    endtask

    task automatic test_reset_mid_split();
        set_in(1'b1, 4'b1111, 4'b0000, 3, 16, 1'b1);
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b0111) begin failures++; $display("FAIL rms_c0_mask got=%b exp=0111", disp_mask_o); end
        tick();
        rob_free_cnt_i = 7'd0;
        for (int c = 0; c < 5; c++) tick();
        @(negedge clk_i);
        checks++; if (stall_cnt_o !== m_stall || stall_cnt_o === 32'd0) begin failures++; $display("FAIL rms_stall got=%0d exp=%0d", stall_cnt_o, m_stall); end
        rst_i = 1'b1;
        rob_free_cnt_i = 7'd8;
        @(negedge clk_i);
        checks++; if (disp_mask_o !== 4'b0000 || grp_ready_o !== 1'b0) begin failures++; $display("FAIL rms_rst_out got=%b/%b exp=0000/0", disp_mask_o, grp_ready_o); end
        tick();
        rst_i = 1'b0;
        set_in(1'b1, 4'b0000, 4'b0000, 8, 16, 1'b1);
        @(negedge clk_i);
        checks++; if (grp_ready_o !== 1'b1 || disp_fire_o !== 1'b0) begin failures++; $display("FAIL rms_empty got=%b/%b exp=1/0", grp_ready_o, disp_fire_o); end
        checks++; if (stall_cnt_o !== 32'd0 || split_cnt_o !== 32'd0) begin failures++; $display("FAIL rms_counters got=%0d/%0d exp=0/0", stall_cnt_o, split_cnt_o); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            if (!need_hold) begin
                grp_valid_i      = ($urandom_range(0, 9) != 0);
                grp_slot_valid_i = 4'($urandom);
                grp_is_store_i   = 4'($urandom);
            end
            rob_free_cnt_i = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 64)) : 7'($urandom_range(0, 5));
            sb_free_cnt_i  = 5'($urandom_range(0, 2));
            ds_ready_i     = ($urandom_range(0, 4) != 0);
            flush_i        = ($urandom_range(0, 24) == 0);
            rst_i          = ($urandom_range(0, 59) == 0);
            @(negedge clk_i);
            eval_model();
            checks++; if (disp_mask_o !== e_mask) begin failures++; $display("FAIL rnd%0d_mask got=%b exp=%b", n, disp_mask_o, e_mask); end
            checks++; if (sb_alloc_req_o !== e_alloc) begin failures++; $display("FAIL rnd%0d_alloc got=%b exp=%b", n, sb_alloc_req_o, e_alloc); end
            checks++; if (disp_fire_o !== e_fire) begin failures++; $display("FAIL rnd%0d_fire got=%b exp=%b", n, disp_fire_o, e_fire); end
            checks++; if (grp_ready_o !== e_ready) begin failures++; $display("FAIL rnd%0d_ready got=%b exp=%b", n, grp_ready_o, e_ready); end
            checks++; if (stall_cnt_o !== m_stall) begin failures++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", n, stall_cnt_o, m_stall); end
            checks++; if (split_cnt_o !== m_splits) begin failures++; $display("FAIL rnd%0d_split got=%0d exp=%0d", n, split_cnt_o, m_splits); end
            tick();
        end
        rst_i = 1'b0;
        flush_i = 1'b0;
    endtask

    initial begin
        m_split = 0; m_rem = '0; m_stall = '0; m_splits = '0; need_hold = 0;
        test_reset();
        test_full_group();
        test_store_split();
        test_rob_limit();
        test_sb_stop();
        test_flush();
        test_reset_mid_split();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rename_dispatch_sched.md
Name: rename_dispatch_sched

Overview:
- Sequences decode groups into the rename stage.
- Each cycle it selects the largest in-order prefix of the pending slots that fits three limits: free ROB entries, free Store Buffer entries, and the per-cycle store allocation limit.
- When a group cannot go in one cycle, it holds the unsent remainder over following cycles (group splitting). It acknowledges the decode group only when every valid slot has been dispatched.
- Sits between the decoder output register and rename. Its slot mask becomes the dec_valid input of rename.

Parameters:
- DISPATCH_WIDTH, 4, slots per decode group (equals Cfg.INSTR_PER_FETCH).
- ROB_DEPTH, 64, ROB entries; ROB_CNT_W = $clog2(ROB_DEPTH+1).
- SB_DEPTH, 16, Store Buffer entries; SB_CNT_W = $clog2(SB_DEPTH+1).
- MAX_ST_PER_CYCLE, 1, maximum stores dispatched in one cycle.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  pipeline flush.
- grp_valid_i  in  1  decode group present; held stable until grp_ready_o.
- grp_slot_valid_i  in  DISPATCH_WIDTH  per-slot valid.
- grp_is_store_i  in  DISPATCH_WIDTH  per-slot store flag.
- grp_ready_o  out  1  group fully dispatched (or empty); decoder may advance.
- rob_free_cnt_i  in  ROB_CNT_W  free ROB entries this cycle.
- sb_free_cnt_i  in  SB_CNT_W  free SB entries this cycle.
- ds_ready_i  in  1  rename/issue can accept this cycle.
- disp_mask_o  out  DISPATCH_WIDTH  slots dispatched this cycle (to rename dec_valid).
- sb_alloc_req_o  out  DISPATCH_WIDTH  disp_mask_o & grp_is_store_i.
- disp_fire_o  out  1  |disp_mask_o.
- stall_cnt_o  out  32  cycles with pending slots and nothing dispatched.
- split_cnt_o  out  32  groups that needed more than one cycle.

Behaviour:
- One clock clk_i. Reset rst_i is synchronous and active-high.
- State IDLE / SPLIT, with register rem_q[DISPATCH_WIDTH].
- pending = (state==IDLE) ? grp_slot_valid_i : rem_q, gated by grp_valid_i.
- Selection (combinational, zero latency):
  - Walk slots 0..W-1 in order, skipping invalid slots.
  - Accept slot i while both hold: (accepted count + 1) <= rob_free_cnt_i, and if it is a store, (accepted stores + 1) <= min(sb_free_cnt_i, MAX_ST_PER_CYCLE).
  - The first valid slot that fails stops selection. No later slot is taken, so order is strictly preserved.
  - Comparisons are zero-extended to 32 bits.
- If ds_ready_i=0 or flush_i=1: disp_mask_o=0.
- Let done = (pending & ~disp_mask_o)==0.
- grp_ready_o = grp_valid_i & done & !flush_i. An empty group (all slot_valid 0) is acknowledged in its first cycle with no fire.
- Transitions:
  - IDLE, done: stay IDLE.
  - IDLE, not done but some slot fired: rem_q <= pending & ~disp_mask_o; go SPLIT; split_cnt++.
  - IDLE, nothing fired: stay IDLE; stall_cnt++ if pending != 0.
  - SPLIT, done: go IDLE; rem_q <= 0.
  - SPLIT, partial: rem_q <= rem_q & ~disp_mask_o.
  - SPLIT, nothing fired: hold; stall_cnt++.
- flush_i: next state IDLE, rem_q <= 0, all outputs 0 in the flush cycle. Counters are not incremented in the flush cycle.
- Reset:
  - state IDLE, rem_q 0, stall_cnt_o 0, split_cnt_o 0.
  - While rst_i is high, disp_mask_o, sb_alloc_req_o, disp_fire_o and grp_ready_o are forced to 0.
  - Reset mid-split discards the remainder.
- Counters wrap mod 2^32.
- rst_i has priority over flush_i. flush_i has priority over all dispatch.
- Upstream contract: grp_valid_i=0 while in SPLIT is a protocol error. Flag it with an assertion; no recovery logic.

Decomposition:
- Shared package (rename_pkg):
  - sched_state_e {IDLE, SPLIT}.
  - ROB_CNT_W / SB_CNT_W localparam functions.
  - Default MAX_ST_PER_CYCLE.
- One sub-module, dispatch_prefix_sel: purely combinational prefix selector.
  - Inputs: pending, is_store, rob_free, st_budget.
  - Outputs: mask.
  - Reused later by the FP/vector dispatch path.

Test Plan:
- Group of 4 ALU ops, rob_free=8, sb_free=16, ds_ready=1 -> disp_mask=1111, grp_ready=1 same cycle, state stays IDLE, split_cnt=0.
- Slots {ALU, ST, ST, ALU}, MAX_ST=1, rob_free=8:
  - cycle0 mask=0011, grp_ready=0, rem=1100, split_cnt=1.
  - cycle1 mask=1100, grp_ready=1, back to IDLE.
- Slots 1111 with rob_free=2 then 0 (one cycle) then 8:
  - c0 mask=0011.
  - c1 mask=0000, stall_cnt=1.
  - c2 mask=1100, grp_ready=1.
- Slot_valid=1010, sb_free=0, slot1 is store, slot3 ALU -> mask=0000 (in-order stop at slot1), stall_cnt increments each cycle until sb_free=1, then mask=1010.
- Flush asserted in SPLIT with rem=1100 -> same cycle mask=0 and grp_ready=0; next cycle state IDLE, rem=0. A new group 0001 dispatches immediately.
- rst_i asserted mid-split (rem=1000, stall_cnt=5) -> next cycle all outputs 0, counters 0, state IDLE. An empty group (slot_valid=0000) after reset gives grp_ready=1, disp_fire=0.
